// File: rtl/input_process_spi_if.sv
// Handshake/bus bundle for input_process_spi: serial receive side, FIFO read
// port, status flags and word counter.
interface input_process_spi_if #(
    parameter int WIDTH = 16
);
    logic             RX_DATA;
    logic             RX_LOAD;
    logic [WIDTH-1:0] DATA;
    logic             VALID;
    logic             READY;
    logic             BUSY;
    logic             FRAME_ERR;
    logic             OVERFLOW;
    logic             CLR_FLAGS;
    logic [15:0]      WORD_CNT;

    modport master (
        output RX_DATA, RX_LOAD, READY, CLR_FLAGS,
        input  DATA, VALID, BUSY, FRAME_ERR, OVERFLOW, WORD_CNT
    );

    modport slave (
        input  RX_DATA, RX_LOAD, READY, CLR_FLAGS,
        output DATA, VALID, BUSY, FRAME_ERR, OVERFLOW, WORD_CNT
    );
endinterface

// File: rtl/input_process_spi.sv
// SPI receive path: deserializes RX_DATA/RX_LOAD into WIDTH-bit words, buffers
// them in a DEPTH-entry FIFO with a registered head, and tracks error flags.
module input_process_spi #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input logic          CLK,
    input logic          RST,
    input_process_spi_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      word_cnt_q, word_cnt_d;

    logic [WIDTH-1:0] word;
    logic             full_frame, push, pop, drop, short_frame;

    always_comb begin
        word        = {shift_q[WIDTH-2:0], bus.RX_DATA};
        full_frame  = (bit_cnt_q >= BIT_LAST);
        pop         = (cnt_q != '0) && bus.READY;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push        = bus.RX_LOAD && full_frame && ((cnt_q != CNT_FULL) || pop);
        drop        = bus.RX_LOAD && full_frame && !push;
        short_frame = bus.RX_LOAD && !full_frame;

        shift_d = word;
        if (bus.RX_LOAD)
            bit_cnt_d = '0;
        else if (bit_cnt_q == BIT_MAX)
            bit_cnt_d = bit_cnt_q;
        else
            bit_cnt_d = bit_cnt_q + BIT_ONE;

        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr_q] = word;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CNT_ONE;
        else if (pop && !push)
            cnt_d = cnt_q - CNT_ONE;

        // Head register: bypass the incoming word when it becomes the only entry.
        data_d = data_q;
        if (cnt_d != '0) begin
            if ((cnt_q == '0) || ((cnt_q == CNT_ONE) && pop))
                data_d = word;
            else
                data_d = mem_q[rd_ptr_d];
        end

        word_cnt_d  = push ? word_cnt_q + 16'd1 : word_cnt_q;
        frame_err_d = short_frame ? 1'b1 : (bus.CLR_FLAGS ? 1'b0 : frame_err_q);
        overflow_d  = drop        ? 1'b1 : (bus.CLR_FLAGS ? 1'b0 : overflow_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign bus.DATA      = data_q;
    assign bus.VALID     = (cnt_q != '0);
    assign bus.BUSY      = (bit_cnt_q != '0) && (bit_cnt_q != BIT_MAX);
    assign bus.FRAME_ERR = frame_err_q;
    assign bus.OVERFLOW  = overflow_q;
    assign bus.WORD_CNT  = word_cnt_q;
endmodule

// File: tb/tb_input_process_spi.sv
// Scoreboard bench for input_process_spi: words expected at the FIFO output are
// queued when sent and compared as they are popped.
module tb_input_process_spi;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_wc;

    input_process_spi_if #(.WIDTH(16)) bus ();

    input_process_spi #(.DEPTH(4), .WIDTH(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every handshake pops the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.VALID === 1'b1 && bus.READY === 1'b1) begin
            if (sb.size() == 0)
                check("unexpected_pop", 32'(bus.DATA), 32'hFFFF_FFFF);
            else
                check("data", 32'(bus.DATA), 32'(sb.pop_front()));
        end
    end

    // Entered and left at posedge+1; last bit of the frame carries RX_LOAD.
    task automatic send_word(input logic [15:0] w, input int nbits, input bit store,
                             input bit ready_at_load, input bit clr_at_load, input bit chk_busy);
        for (int i = 0; i < nbits; i++) begin
            bus.RX_DATA = w[nbits-1-i];
            bus.RX_LOAD = (i == nbits - 1);
            if (i == nbits - 1) begin
                if (ready_at_load) bus.READY = 1'b1;
                if (clr_at_load) bus.CLR_FLAGS = 1'b1;
                if (store) begin
                    sb.push_back(w);
                    exp_wc = exp_wc + 16'd1;
                end
            end
            if (chk_busy) begin
                @(negedge clk);
                check("busy", 32'(bus.BUSY), 32'(i != 0));
            end
            @(posedge clk); #1;
        end
        bus.RX_LOAD   = 1'b0;
        bus.RX_DATA   = 1'b0;
        bus.CLR_FLAGS = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_clr();
        bus.CLR_FLAGS = 1'b1;
        @(posedge clk); #1;
        bus.CLR_FLAGS = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        exp_wc = '0;
        bus.RX_DATA = 1'b0;
        bus.RX_LOAD = 1'b0;
        bus.READY = 1'b0;
        bus.CLR_FLAGS = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.VALID), 32'd0);
        check("rst_data", 32'(bus.DATA), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_ferr", 32'(bus.FRAME_ERR), 32'd0);
        check("rst_ovf", 32'(bus.OVERFLOW), 32'd0);
        check("rst_wcnt", 32'(bus.WORD_CNT), 32'd0);
        rst = 1'b0;

        // Single word with BUSY profile
        bus.READY = 1'b1;
        send_word(16'hA5C3, 16, 1, 0, 0, 1);
        check("single_valid", 32'(bus.VALID), 32'd1);
        @(posedge clk); #1;
        check("single_valid_drop", 32'(bus.VALID), 32'd0);
        check("single_wcnt", 32'(bus.WORD_CNT), 32'd1);
        check("single_ferr", 32'(bus.FRAME_ERR), 32'd0);
        check("single_ovf", 32'(bus.OVERFLOW), 32'd0);

        // Back-to-back with backpressure, then overflow
        bus.READY = 1'b0;
        send_word(16'h0001, 16, 1, 0, 0, 0);
        send_word(16'h8000, 16, 1, 0, 0, 0);
        send_word(16'hFFFF, 16, 1, 0, 0, 0);
        send_word(16'h1234, 16, 1, 0, 0, 0);
        check("bp_wcnt", 32'(bus.WORD_CNT), 32'(exp_wc));
        check("bp_ovf0", 32'(bus.OVERFLOW), 32'd0);
        send_word(16'hDEAD, 16, 0, 0, 0, 0);
        check("bp_ovf1", 32'(bus.OVERFLOW), 32'd1);
        check("bp_wcnt_after_drop", 32'(bus.WORD_CNT), 32'(exp_wc));
        bus.READY = 1'b1;
        wait_empty();
        check("bp_valid_empty", 32'(bus.VALID), 32'd0);
        check("bp_ovf_sticky", 32'(bus.OVERFLOW), 32'd1);
        pulse_clr();
        check("bp_ovf_clr", 32'(bus.OVERFLOW), 32'd0);
        check("clr_keeps_wcnt", 32'(bus.WORD_CNT), 32'(exp_wc));

        // Push into a full FIFO in the same cycle as a pop
        bus.READY = 1'b0;
        send_word(16'h1111, 16, 1, 0, 0, 0);
        send_word(16'h2222, 16, 1, 0, 0, 0);
        send_word(16'h3333, 16, 1, 0, 0, 0);
        send_word(16'h4444, 16, 1, 0, 0, 0);
        send_word(16'h5555, 16, 1, 1, 0, 0);
        check("pp_ovf", 32'(bus.OVERFLOW), 32'd0);
        check("pp_wcnt", 32'(bus.WORD_CNT), 32'(exp_wc));
        wait_empty();

        // Short frame followed by a good frame
        send_word(16'h0F0F, 16, 1, 0, 0, 0);
        send_word(16'h01FF, 9, 0, 0, 0, 0);
        check("short_ferr", 32'(bus.FRAME_ERR), 32'd1);
        check("short_wcnt", 32'(bus.WORD_CNT), 32'(exp_wc));
        send_word(16'h5A5A, 16, 1, 0, 0, 0);
        check("after_short_wcnt", 32'(bus.WORD_CNT), 32'(exp_wc));
        wait_empty();

        // Set beats clear in the same cycle
        pulse_clr();
        check("race_pre_clr", 32'(bus.FRAME_ERR), 32'd0);
        send_word(16'h3C3C, 16, 1, 0, 0, 0);
        send_word(16'h0015, 5, 0, 0, 1, 0);
        check("race_ferr_set", 32'(bus.FRAME_ERR), 32'd1);
        pulse_clr();
        check("race_ferr_clr", 32'(bus.FRAME_ERR), 32'd0);

        // RX_LOAD on consecutive cycles
        send_word(16'h7777, 16, 1, 0, 0, 0);
        send_word(16'h0001, 1, 0, 0, 0, 0);
        check("dbl_load_ferr", 32'(bus.FRAME_ERR), 32'd1);
        check("dbl_load_wcnt", 32'(bus.WORD_CNT), 32'(exp_wc));
        wait_empty();

        // Reset mid-frame with words queued
        bus.READY = 1'b0;
        send_word(16'h1111, 16, 1, 0, 0, 0);
        send_word(16'h2222, 16, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            bus.RX_DATA = 1'b1;
            @(posedge clk); #1;
        end
        check("mid_busy", 32'(bus.BUSY), 32'd1);
        bus.RX_DATA = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", 32'(bus.VALID), 32'd0);
        check("mid_rst_data", 32'(bus.DATA), 32'd0);
        check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        check("mid_rst_ferr", 32'(bus.FRAME_ERR), 32'd0);
        check("mid_rst_wcnt", 32'(bus.WORD_CNT), 32'd0);
        rst = 1'b0;
        sb.delete();
        exp_wc = '0;
        bus.READY = 1'b1;
        send_word(16'h00FF, 16, 1, 0, 0, 0);
        check("post_rst_valid", 32'(bus.VALID), 32'd1);
        check("post_rst_wcnt", 32'(bus.WORD_CNT), 32'd1);
        wait_empty();
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
